// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: ID-stage decoder fields and pipeline sequencing controls.
// The pipeline side uses master, the hazard controller uses slave.
interface pipe_hazard_ctrl_if #(
    parameter int NUM_REGS = 32,
    parameter int REG_SEL  = $clog2(NUM_REGS)
);
    logic               id_valid;
    logic [REG_SEL-1:0] id_rs1;
    logic [REG_SEL-1:0] id_rs2;
    logic [REG_SEL-1:0] id_rd;
    logic               id_reg_write;
    logic               id_mem_read;
    logic               ex_taken;
    logic               mem_busy;

    logic               pc_en;
    logic               if_id_en;
    logic               if_id_flush;
    logic               id_ex_flush;
    logic               ex_mem_en;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, ex_taken, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, ex_taken, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, ex_mem_en, fwd_a, fwd_b
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: shadow EX/MEM/WB usage fields, stall/flush sequencing, ALU forwarding.
// Define PIPE_HAZARD_PERF_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module pipe_hazard_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int REG_SEL  = $clog2(NUM_REGS)
) (
    input  logic clk,
    input  logic rst_n,
    pipe_hazard_ctrl_if.slave bus
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef struct packed {
        logic               valid;
        logic [REG_SEL-1:0] rs1;
        logic [REG_SEL-1:0] rs2;
        logic [REG_SEL-1:0] rd;
        logic               rw;
        logic               mr;
    } ex_stage_t;

    typedef struct packed {
        logic               valid;
        logic [REG_SEL-1:0] rd;
        logic               rw;
        logic               mr;
    } mem_stage_t;

    typedef struct packed {
        logic               valid;
        logic [REG_SEL-1:0] rd;
        logic               rw;
    } wb_stage_t;

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;
    logic       load_use;

    // Loads are excluded from EX/MEM forwarding: their data only exists from MEM/WB on.
    function automatic logic [1:0] fwd_sel(input logic [REG_SEL-1:0] rs,
                                           input mem_stage_t m, input wb_stage_t w);
        if (m.valid && m.rw && !m.mr && (m.rd != '0) && (m.rd == rs))
            return 2'b01;
        else if (w.valid && w.rw && (w.rd != '0) && (w.rd == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = bus.id_valid & ex_q.valid & ex_q.mr & (ex_q.rd != '0) &
                      ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (bus.ex_mem_en) begin
            wb_d.valid  = mem_q.valid;
            wb_d.rd     = mem_q.rd;
            wb_d.rw     = mem_q.rw;
            mem_d.valid = ex_q.valid;
            mem_d.rd    = ex_q.rd;
            mem_d.rw    = ex_q.rw;
            mem_d.mr    = ex_q.mr;
            if (bus.id_ex_flush) begin
                ex_d = '0;
            end else begin
                ex_d.valid = bus.id_valid;
                ex_d.rs1   = bus.id_rs1;
                ex_d.rs2   = bus.id_rs2;
                ex_d.rd    = bus.id_rd;
                ex_d.rw    = bus.id_reg_write;
                ex_d.mr    = bus.id_mem_read;
            end
        end
    end

    // Priority: reset, memory wait, taken redirect, load-use bubble, free-run.
    always_comb begin
        bus.pc_en       = 1'b1;
        bus.if_id_en    = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.ex_mem_en   = 1'b1;
        bus.fwd_a       = 2'b00;
        bus.fwd_b       = 2'b00;
        if (!rst_n) begin
            bus.pc_en       = 1'b0;
            bus.if_id_en    = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else begin
            bus.fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
            bus.fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);
            if (bus.mem_busy) begin
                bus.pc_en     = 1'b0;
                bus.if_id_en  = 1'b0;
                bus.ex_mem_en = 1'b0;
            end else if (bus.ex_taken) begin
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
            end else if (load_use) begin
                bus.pc_en       = 1'b0;
                bus.if_id_en    = 1'b0;
                bus.id_ex_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.mem_busy || (load_use && !bus.ex_taken))
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (bus.ex_taken && !bus.mem_busy)
            flush_cnt_d = flush_cnt_q + 32'd1;
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule
